// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StWrDat,
    StRdDat,
    StDone
  } state_e;

  // Number of flops between an SPI pin and the clk_i-domain logic.
  localparam int unsigned SyncDepth = 2;

  // The R/W flag is the first header bit on the wire, i.e. the header MSB.
  function automatic int unsigned rw_bit(input int unsigned h_lng);
    return h_lng - 1;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings CS, SCLK and MOSI into the clk_i domain and flags SCLK transitions.
module spi_slave_sync
  import spi_slave_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic spi_cs_i,
  input  logic spi_clk_i,
  input  logic spi_mosi_i,
  input  logic clk_idle_i,
  output logic cs_s,
  output logic mosi_s,
  output logic rise_p,
  output logic fall_p
);

  logic [SyncDepth-1:0] cs_q;
  logic [SyncDepth-1:0] clk_q;
  logic [SyncDepth-1:0] mosi_q;
  logic                 clk_hist_q;
  logic                 clk_s;

  assign cs_s   = cs_q[SyncDepth-1];
  assign clk_s  = clk_q[SyncDepth-1];
  assign mosi_s = mosi_q[SyncDepth-1];

  // Synchroniser chains plus one SCLK history flop for edge detection.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cs_q       <= '1;
      clk_q      <= '0;
      mosi_q     <= '0;
      clk_hist_q <= 1'b0;
    end else begin
      cs_q       <= {cs_q[SyncDepth-2:0], spi_cs_i};
      clk_q      <= {clk_q[SyncDepth-2:0], spi_clk_i};
      mosi_q     <= {mosi_q[SyncDepth-2:0], spi_mosi_i};
      // While deselected the history tracks the configured idle level, so the
      // first edge of a frame is measured against where SCLK should rest.
      clk_hist_q <= cs_s ? clk_idle_i : clk_s;
    end
  end

  assign rise_p = clk_s & ~clk_hist_q;
  assign fall_p = ~clk_s & clk_hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: decodes header/data frames into register writes and reads.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned H_LNG = 16,
  parameter int unsigned L_LNG = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             spi_cs_i,
  input  logic             spi_clk_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  output logic             spi_miso_t,
  input  logic             cfg_clk_idle_i,
  input  logic             cfg_clk_rd_edg_i,
  output logic [H_LNG-2:0] addr_o,
  output logic             wr_o,
  output logic [L_LNG-1:0] wr_dat_o,
  output logic             rd_req_o,
  input  logic             rd_ack_i,
  input  logic [L_LNG-1:0] rd_dat_i,
  output logic             sts_busy_o,
  output logic             sts_abort_o,
  output logic             sts_rd_late_o
);

  localparam int unsigned RwBit = rw_bit(H_LNG);

  logic cs_s, mosi_s, rise_p, fall_p;
  logic sample_p, tx_p, cs_fall, cs_rise;

  state_e           state_q;
  logic [4:0]       bit_cnt_q;
  logic [H_LNG-1:0] hdr_sr_q;
  logic [L_LNG-1:0] dat_sr_q;
  logic [L_LNG-1:0] tx_sr_q;
  logic             rd_pend_q, tx_first_q;
  logic             cs_d1_q, armed_q, clk_idle_q;
  logic [1:0]       sync_fill_q;
  logic [H_LNG-2:0] addr_q;
  logic [L_LNG-1:0] wr_dat_q;
  logic             wr_q, rd_req_q, abort_q, late_q, miso_q, miso_t_q;

  logic [H_LNG-1:0] hdr_next;
  logic [L_LNG:0]   dat_ext;
  logic [L_LNG-1:0] dat_next;
  logic [L_LNG-1:0] tx_src;
  logic [L_LNG-1:0] tx_shift;

  spi_slave_sync u_sync (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .spi_cs_i   (spi_cs_i),
    .spi_clk_i  (spi_clk_i),
    .spi_mosi_i (spi_mosi_i),
    .clk_idle_i (clk_idle_q),
    .cs_s       (cs_s),
    .mosi_s     (mosi_s),
    .rise_p     (rise_p),
    .fall_p     (fall_p)
  );

  assign sample_p = cfg_clk_rd_edg_i ? rise_p : fall_p;
  assign tx_p     = cfg_clk_rd_edg_i ? fall_p : rise_p;
  // Falling CS only counts once the synchroniser has shown CS high after reset,
  // so a frame cut by reset is never picked up halfway.
  assign cs_fall  = armed_q & cs_d1_q & ~cs_s;
  assign cs_rise  = ~cs_d1_q & cs_s;

  assign hdr_next = {hdr_sr_q[H_LNG-2:0], mosi_s};
  assign dat_ext  = {dat_sr_q, mosi_s};
  assign dat_next = dat_ext[L_LNG-1:0];
  // An ack arriving together with the first tx edge supplies that bit directly.
  assign tx_src   = rd_pend_q ? rd_dat_i : tx_sr_q;
  assign tx_shift = tx_src << 1;

  // Frame state machine with registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      hdr_sr_q    <= '0;
      dat_sr_q    <= '0;
      tx_sr_q     <= '0;
      rd_pend_q   <= 1'b0;
      tx_first_q  <= 1'b0;
      cs_d1_q     <= 1'b1;
      armed_q     <= 1'b0;
      clk_idle_q  <= 1'b0;
      sync_fill_q <= '0;
      addr_q      <= '0;
      wr_dat_q    <= '0;
      wr_q        <= 1'b0;
      rd_req_q    <= 1'b0;
      abort_q     <= 1'b0;
      late_q      <= 1'b0;
      miso_q      <= 1'b0;
      miso_t_q    <= 1'b1;
    end else begin
      cs_d1_q  <= cs_s;
      wr_q     <= 1'b0;
      rd_req_q <= 1'b0;
      abort_q  <= 1'b0;
      late_q   <= 1'b0;
      if (sync_fill_q != 2'(SyncDepth)) sync_fill_q <= sync_fill_q + 2'd1;
      else if (cs_s)                    armed_q     <= 1'b1;
      if (cs_s) clk_idle_q <= cfg_clk_idle_i;

      unique case (state_q)
        StIdle: begin
          miso_t_q <= 1'b1;
          if (cs_fall) begin
            state_q   <= StHdr;
            bit_cnt_q <= 5'(H_LNG);
          end
        end
        StHdr: begin
          if (cs_rise) begin
            state_q <= StIdle;
            abort_q <= 1'b1;
          end else if (sample_p) begin
            hdr_sr_q  <= hdr_next;
            bit_cnt_q <= bit_cnt_q - 5'd1;
            if (bit_cnt_q == 5'd1) begin
              addr_q    <= hdr_next[H_LNG-2:0];
              bit_cnt_q <= 5'(L_LNG);
              if (hdr_next[RwBit]) begin
                state_q    <= StRdDat;
                rd_req_q   <= 1'b1;
                rd_pend_q  <= 1'b1;
                tx_first_q <= 1'b1;
                tx_sr_q    <= '0;
                miso_t_q   <= 1'b0;
              end else begin
                state_q <= StWrDat;
              end
            end
          end
        end
        StWrDat: begin
          if (cs_rise) begin
            state_q <= StIdle;
            abort_q <= 1'b1;
          end else if (sample_p) begin
            dat_sr_q  <= dat_next;
            bit_cnt_q <= bit_cnt_q - 5'd1;
            if (bit_cnt_q == 5'd1) begin
              wr_q     <= 1'b1;
              wr_dat_q <= dat_next;
              state_q  <= StDone;
            end
          end
        end
        StRdDat: begin
          if (cs_rise) begin
            state_q   <= StIdle;
            abort_q   <= 1'b1;
            rd_pend_q <= 1'b0;
            miso_t_q  <= 1'b1;
          end else begin
            if (tx_p) begin
              tx_first_q <= 1'b0;
              rd_pend_q  <= 1'b0;
              if (tx_first_q && rd_pend_q && !rd_ack_i) begin
                // No data in time: the whole frame goes out as zeros.
                late_q  <= 1'b1;
                tx_sr_q <= '0;
                miso_q  <= 1'b0;
              end else begin
                miso_q  <= tx_src[L_LNG-1];
                tx_sr_q <= tx_shift;
              end
            end else if (rd_ack_i && rd_pend_q) begin
              tx_sr_q   <= rd_dat_i;
              rd_pend_q <= 1'b0;
            end
            if (sample_p) begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
              if (bit_cnt_q == 5'd1) begin
                state_q   <= StDone;
                rd_pend_q <= 1'b0;
                miso_t_q  <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          miso_t_q <= 1'b1;
          if (cs_rise) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_t    = miso_t_q;
  assign addr_o        = addr_q;
  assign wr_o          = wr_q;
  assign wr_dat_o      = wr_dat_q;
  assign rd_req_o      = rd_req_q;
  assign sts_busy_o    = ~cs_s & (state_q != StIdle);
  assign sts_abort_o   = abort_q;
  assign sts_rd_late_o = late_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives two responders
// (16/16 and 8/8) while a peripheral model answers read requests.
module tb_spi_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, sclk, mosi, cs0, cs1, cfg_idle, cfg_edg, rd_ack;
  logic [15:0] rd_dat;

  logic        miso0, miso_t0, wr0, rdreq0, busy0, abort0, late0;
  logic [14:0] addr0;
  logic [15:0] wrdat0;
  logic        miso1, miso_t1, wr1, rdreq1, busy1, abort1, late1;
  logic [6:0]  addr1;
  logic [7:0]  wrdat1;

  spi_slave #(.H_LNG(16), .L_LNG(16)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .spi_cs_i(cs0), .spi_clk_i(sclk), .spi_mosi_i(mosi),
    .spi_miso_o(miso0), .spi_miso_t(miso_t0), .cfg_clk_idle_i(cfg_idle),
    .cfg_clk_rd_edg_i(cfg_edg), .addr_o(addr0), .wr_o(wr0), .wr_dat_o(wrdat0),
    .rd_req_o(rdreq0), .rd_ack_i(rd_ack), .rd_dat_i(rd_dat), .sts_busy_o(busy0),
    .sts_abort_o(abort0), .sts_rd_late_o(late0)
  );

  spi_slave #(.H_LNG(8), .L_LNG(8)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .spi_cs_i(cs1), .spi_clk_i(sclk), .spi_mosi_i(mosi),
    .spi_miso_o(miso1), .spi_miso_t(miso_t1), .cfg_clk_idle_i(cfg_idle),
    .cfg_clk_rd_edg_i(cfg_edg), .addr_o(addr1), .wr_o(wr1), .wr_dat_o(wrdat1),
    .rd_req_o(rdreq1), .rd_ack_i(rd_ack), .rd_dat_i(rd_dat[7:0]), .sts_busy_o(busy1),
    .sts_abort_o(abort1), .sts_rd_late_o(late1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int hp    = 4;   // SCLK half-period in clk cycles

  int          wr_cnt[2], abort_cnt[2], late_cnt[2], rdreq_cnt[2];
  logic [15:0] last_addr[2], last_dat[2];
  logic [15:0] periph0[int], periph1[int];  // peripheral behind each responder
  logic [15:0] model0[int], model1[int];    // what the master believes it wrote

  int          ack_dly   = 2;
  logic        ack_force = 1'b0;
  logic [15:0] ack_val   = '0;

  int          rst_at_bit = -1;
  logic        snap_pre_t;
  logic [6:0]  snap_out;
  logic [15:0] snap_addr, snap_dat;

  function automatic logic miso_of(input int sel);
    return (sel == 0) ? miso0 : miso1;
  endfunction

  function automatic logic miso_t_of(input int sel);
    return (sel == 0) ? miso_t0 : miso_t1;
  endfunction

  // Pulse counters and the peripheral register file written by wr_o.
  initial begin
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i] = 0; abort_cnt[i] = 0; late_cnt[i] = 0; rdreq_cnt[i] = 0;
      last_addr[i] = '0; last_dat[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (wr0) begin
        wr_cnt[0]++; last_addr[0] = 16'(addr0); last_dat[0] = wrdat0;
        periph0[int'(addr0)] = wrdat0;
      end
      if (wr1) begin
        wr_cnt[1]++; last_addr[1] = 16'(addr1); last_dat[1] = 16'(wrdat1);
        periph1[int'(addr1)] = 16'(wrdat1);
      end
      if (abort0) abort_cnt[0]++;
      if (abort1) abort_cnt[1]++;
      if (late0) late_cnt[0]++;
      if (late1) late_cnt[1]++;
      if (rdreq0) rdreq_cnt[0]++;
      if (rdreq1) rdreq_cnt[1]++;
    end
  end

  // Read responder: answers rd_req after ack_dly cycles.
  initial begin
    logic [15:0] v;
    rd_ack = 1'b0;
    rd_dat = '0;
    forever begin
      @(negedge clk);
      if ((rdreq0 || rdreq1) && ack_dly >= 0) begin
        if (ack_force) v = ack_val;
        else if (rdreq0) v = periph0.exists(int'(addr0)) ? periph0[int'(addr0)] : 16'h0;
        else v = periph1.exists(int'(addr1)) ? periph1[int'(addr1)] : 16'h0;
        repeat (ack_dly) @(negedge clk);
        rd_ack = 1'b1;
        rd_dat = v;
        @(negedge clk);
        rd_ack = 1'b0;
        rd_dat = '0;
      end
    end
  end

  // Behavioural master: one frame of hl+ll bits, MSB first; stops early after
  // stop_bits sampled bits. Returns the data part read from MISO and a count of
  // sample points where the MISO enable disagreed with the frame phase.
  task automatic spi_frame(input int sel, input int hl, input int ll, input logic [15:0] hdr,
                           input logic [15:0] dat, input int stop_bits,
                           output logic [15:0] rd, output int tri_bad);
    int          n, bi;
    logic [31:0] bits;
    logic        nv, is_rd;
    n       = hl + ll;
    bits    = (32'(hdr) << ll) | 32'(dat);
    bi      = 0;
    rd      = '0;
    tri_bad = 0;
    is_rd   = hdr[hl-1];
    sclk    = cfg_idle;
    if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
    if (cfg_idle != cfg_edg) mosi = bits[n-1];
    repeat (hp) @(negedge clk);
    for (int e = 0; e < 2 * n; e++) begin
      nv = ~sclk;
      if (nv == cfg_edg) begin
        if (is_rd && bi >= hl) begin
          rd = {rd[14:0], miso_of(sel)};
          if (miso_t_of(sel) !== 1'b0) tri_bad++;
        end else if (miso_t_of(sel) !== 1'b1) begin
          tri_bad++;
        end
        sclk = nv;
        bi++;
        if (bi == rst_at_bit) begin
          snap_pre_t = miso_t0;
          rstn = 1'b0;
          #1;
          snap_out  = {miso_t0, miso0, wr0, rdreq0, busy0, abort0, late0};
          snap_addr = 16'(addr0);
          snap_dat  = wrdat0;
          @(negedge clk);
          rstn = 1'b1;
        end
      end else begin
        sclk = nv;
        if (bi < n) mosi = bits[n-1-bi];
      end
      repeat (hp) @(negedge clk);
      if (stop_bits < n && bi == stop_bits) break;
    end
    if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
    repeat (hp) @(negedge clk);
    sclk = cfg_idle;
    repeat (hp + 2) @(negedge clk);
  endtask

  task automatic set_mode(input logic idle, input logic edg);
    cfg_idle = idle;
    cfg_edg  = edg;
    sclk     = idle;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    if ({miso_t0, miso0, wr0, rdreq0, busy0, abort0, late0} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_outs0: got %b want 1000000",
               {miso_t0, miso0, wr0, rdreq0, busy0, abort0, late0});
    end
    n_cmp++;
    if (addr0 !== 15'h0) begin n_bad++; $display("FAIL reset_addr0: got %h want 0", addr0); end
    n_cmp++;
    if (wrdat0 !== 16'h0) begin n_bad++; $display("FAIL reset_dat0: got %h want 0", wrdat0); end
    n_cmp++;
    if ({miso_t1, miso1, wr1, rdreq1, busy1, abort1, late1, addr1, wrdat1} !== {7'b1000000, 15'h0})
    begin
      n_bad++;
      $display("FAIL reset_dut1: got %b want 1000000 and zero addr/data",
               {miso_t1, miso1, wr1, rdreq1, busy1, abort1, late1, addr1, wrdat1});
    end
    n_cmp++;
    rstn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_write();
    logic [15:0] rd;
    int tb, w, s;
    set_mode(1'b0, 1'b1);
    w = wr_cnt[0];
    s = abort_cnt[0] + late_cnt[0] + rdreq_cnt[0];
    spi_frame(0, 16, 16, 16'h0012, 16'hA5C3, 32, rd, tb);
    model0[16'h12] = 16'hA5C3;
    if (wr_cnt[0] - w !== 1) begin n_bad++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt[0] - w); end
    n_cmp++;
    if (last_addr[0] !== 16'h0012) begin n_bad++; $display("FAIL wr_addr: got %h want 0012", last_addr[0]); end
    n_cmp++;
    if (last_dat[0] !== 16'hA5C3) begin n_bad++; $display("FAIL wr_data: got %h want a5c3", last_dat[0]); end
    n_cmp++;
    if (abort_cnt[0] + late_cnt[0] + rdreq_cnt[0] - s !== 0) begin
      n_bad++; $display("FAIL wr_status: got %0d extra pulses want 0", abort_cnt[0] + late_cnt[0] + rdreq_cnt[0] - s);
    end
    n_cmp++;
    if (tb !== 0) begin n_bad++; $display("FAIL wr_miso_t: got %0d bad samples want 0", tb); end
    n_cmp++;
  endtask

  task automatic test_read();
    logic [15:0] rd;
    int tb, r, l;
    periph0[16'h34] = 16'hBEEF;
    model0[16'h34]  = 16'hBEEF;
    ack_dly = 2;
    r = rdreq_cnt[0];
    l = late_cnt[0];
    spi_frame(0, 16, 16, 16'h8034, 16'h0000, 32, rd, tb);
    if (rd !== model0[16'h34]) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd, model0[16'h34]); end
    n_cmp++;
    if (rdreq_cnt[0] - r !== 1) begin n_bad++; $display("FAIL rd_req_pulses: got %0d want 1", rdreq_cnt[0] - r); end
    n_cmp++;
    if (tb !== 0) begin n_bad++; $display("FAIL rd_miso_t: got %0d bad samples want 0", tb); end
    n_cmp++;
    if (late_cnt[0] - l !== 0) begin n_bad++; $display("FAIL rd_late_spurious: got %0d want 0", late_cnt[0] - l); end
    n_cmp++;
    if (addr0 !== 15'h34) begin n_bad++; $display("FAIL rd_addr: got %h want 0034", addr0); end
    n_cmp++;
  endtask

  task automatic test_late_ack();
    logic [15:0] rd;
    int tb, l;
    l = late_cnt[0];
    ack_force = 1'b1;
    ack_val   = 16'hFFFF;
    ack_dly   = 8 * hp;   // lands well after the first tx edge
    spi_frame(0, 16, 16, 16'h8001, 16'h0000, 32, rd, tb);
    if (rd !== 16'h0000) begin n_bad++; $display("FAIL late_data: got %h want 0000", rd); end
    n_cmp++;
    if (late_cnt[0] - l !== 1) begin n_bad++; $display("FAIL late_pulses: got %0d want 1", late_cnt[0] - l); end
    n_cmp++;
    // Stray ack between frames, then a normal read must return real data.
    rd_ack = 1'b1; rd_dat = 16'hFFFF;
    @(negedge clk);
    rd_ack = 1'b0; rd_dat = '0;
    ack_force = 1'b0;
    ack_dly   = 1;
    periph0[1] = 16'h0F0F;
    model0[1]  = 16'h0F0F;
    repeat (4) @(negedge clk);
    spi_frame(0, 16, 16, 16'h8001, 16'h0000, 32, rd, tb);
    if (rd !== model0[1]) begin n_bad++; $display("FAIL late_recover: got %h want %h", rd, model0[1]); end
    n_cmp++;
    ack_dly = 2;
  endtask

  task automatic test_abort();
    logic [15:0] rd;
    int tb, a, w;
    a = abort_cnt[0];
    w = wr_cnt[0];
    spi_frame(0, 16, 16, 16'h0077, 16'h9999, 20, rd, tb);
    if (abort_cnt[0] - a !== 1) begin n_bad++; $display("FAIL abort_pulses: got %0d want 1", abort_cnt[0] - a); end
    n_cmp++;
    if (wr_cnt[0] - w !== 0) begin n_bad++; $display("FAIL abort_no_wr: got %0d want 0", wr_cnt[0] - w); end
    n_cmp++;
    spi_frame(0, 16, 16, 16'h0005, 16'h1234, 32, rd, tb);
    model0[5] = 16'h1234;
    if (wr_cnt[0] - w !== 1 || last_addr[0] !== 16'h0005 || last_dat[0] !== 16'h1234) begin
      n_bad++;
      $display("FAIL abort_next_wr: got n=%0d a=%h d=%h want n=1 a=0005 d=1234",
               wr_cnt[0] - w, last_addr[0], last_dat[0]);
    end
    n_cmp++;
  endtask

  task automatic test_modes();
    logic [15:0] rd;
    logic [1:0]  mb;
    int tb, tb2, w;
    for (int m = 0; m < 4; m++) begin
      mb = 2'(m);
      set_mode(mb[1], mb[0]);
      periph1.delete(3);
      w = wr_cnt[1];
      spi_frame(1, 8, 8, 16'h0003, 16'h005A, 16, rd, tb);
      model1[3] = 16'h005A;
      if (wr_cnt[1] - w !== 1 || last_addr[1] !== 16'h0003 || last_dat[1] !== 16'h005A) begin
        n_bad++;
        $display("FAIL mode%0d_wr: got n=%0d a=%h d=%h want n=1 a=0003 d=005a",
                 m, wr_cnt[1] - w, last_addr[1], last_dat[1]);
      end
      n_cmp++;
      spi_frame(1, 8, 8, 16'h0083, 16'h0000, 16, rd, tb2);
      if (rd[7:0] !== model1[3][7:0] || tb + tb2 !== 0) begin
        n_bad++;
        $display("FAIL mode%0d_rd: got %h (tri errs %0d) want %h (0)", m, rd[7:0], tb + tb2,
                 model1[3][7:0]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, d, exp;
    logic [14:0] a;
    logic [1:0]  mb;
    int tb;
    for (int i = 0; i < 6; i++) begin
      mb = 2'($urandom_range(0, 3));
      hp = int'($urandom_range(4, 6));
      set_mode(mb[1], mb[0]);
      a = 15'($urandom);
      d = 16'($urandom);
      spi_frame(0, 16, 16, {1'b0, a}, d, 32, rd, tb);
      model0[int'(a)] = d;
      if (last_addr[0] !== 16'(a) || last_dat[0] !== d) begin
        n_bad++;
        $display("FAIL rand%0d_wr: got a=%h d=%h want a=%h d=%h", i, last_addr[0], last_dat[0], a, d);
      end
      n_cmp++;
      ack_dly = int'($urandom_range(0, 2));
      spi_frame(0, 16, 16, {1'b1, a}, 16'h0000, 32, rd, tb);
      exp = model0[int'(a)];
      if (rd !== exp || tb !== 0) begin
        n_bad++;
        $display("FAIL rand%0d_rd: got %h (tri errs %0d) want %h (0)", i, rd, tb, exp);
      end
      n_cmp++;
    end
    hp = 4;
    ack_dly = 2;
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    int tb, w, a, l;
    set_mode(1'b0, 1'b1);
    w = wr_cnt[0]; a = abort_cnt[0]; l = late_cnt[0];
    rst_at_bit = 20;
    spi_frame(0, 16, 16, 16'h8034, 16'h0000, 32, rd, tb);
    rst_at_bit = -1;
    if (snap_pre_t !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_read: miso_t got %b want 0", snap_pre_t); end
    n_cmp++;
    if (snap_out !== 7'b1000000 || snap_addr !== 16'h0 || snap_dat !== 16'h0) begin
      n_bad++;
      $display("FAIL rstmid_outs: got %b a=%h d=%h want 1000000 a=0000 d=0000",
               snap_out, snap_addr, snap_dat);
    end
    n_cmp++;
    if (wr_cnt[0] - w + abort_cnt[0] - a + late_cnt[0] - l !== 0) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got %0d pulses want 0",
               wr_cnt[0] - w + abort_cnt[0] - a + late_cnt[0] - l);
    end
    n_cmp++;
    spi_frame(0, 16, 16, 16'h0066, 16'hC0DE, 32, rd, tb);
    model0[16'h66] = 16'hC0DE;
    if (wr_cnt[0] - w !== 1 || last_addr[0] !== 16'h0066 || last_dat[0] !== 16'hC0DE) begin
      n_bad++;
      $display("FAIL rstmid_next: got n=%0d a=%h d=%h want n=1 a=0066 d=c0de",
               wr_cnt[0] - w, last_addr[0], last_dat[0]);
    end
    n_cmp++;
  endtask

  initial begin
    rstn = 1'b0; sclk = 1'b0; mosi = 1'b0; cs0 = 1'b1; cs1 = 1'b1;
    cfg_idle = 1'b0; cfg_edg = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_late_ack();
    test_abort();
    test_modes();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
